// File: rtl/lfsr_checker.sv
// Receive-side checker for the 8-bit Fibonacci LFSR pattern: self-seeds from the
// incoming words, locks after a run of good predictions, then flywheels and counts errors.
module lfsr_checker #(
  parameter logic [7:0] TAP_MASK = 8'h0E,
  parameter int         LOCK_CNT = 4,
  parameter int         LOSS_CNT = 3,
  parameter int         CNT_W    = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [7:0]       din,
  input  logic             din_valid,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {HUNT, VERIFY, LOCK} state_t;

  localparam logic [3:0] LOCK_N = 4'(LOCK_CNT);
  localparam logic [3:0] LOSS_N = 4'(LOSS_CNT);

  state_t     state;
  logic [7:0] exp_word;
  logic [3:0] match_cnt;
  logic [3:0] miss_cnt;

  function automatic logic [7:0] nxt(input logic [7:0] s);
    return {s[6:0], ^(s & TAP_MASK)};
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= HUNT;
      exp_word  <= 8'h00;
      match_cnt <= 4'd0;
      miss_cnt  <= 4'd0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_cnt   <= '0;
    end else begin
      err_pulse <= 1'b0;
      if (clr_cnt) err_cnt <= '0;
      if (din_valid) begin
        unique case (state)
          HUNT: begin
            // all-zero is the LFSR lock-up value and can never seed the predictor
            if (din != 8'h00) begin
              exp_word  <= nxt(din);
              match_cnt <= 4'd0;
              state     <= VERIFY;
            end
          end
          VERIFY: begin
            if (din == exp_word) begin
              exp_word <= nxt(din);
              if (match_cnt + 4'd1 == LOCK_N) begin
                match_cnt <= 4'd0;
                miss_cnt  <= 4'd0;
                state     <= LOCK;
                locked    <= 1'b1;
              end else begin
                match_cnt <= match_cnt + 4'd1;
              end
            end else if (din != 8'h00) begin
              exp_word  <= nxt(din);
              match_cnt <= 4'd0;
            end else begin
              match_cnt <= 4'd0;
              state     <= HUNT;
            end
          end
          LOCK: begin
            // flywheel: prediction advances from its own state, never from din
            exp_word <= nxt(exp_word);
            if (din == exp_word) begin
              miss_cnt <= 4'd0;
            end else begin
              err_pulse <= 1'b1;
              if (clr_cnt)       err_cnt <= CNT_W'(1);
              else if (~&err_cnt) err_cnt <= err_cnt + CNT_W'(1);
              if (miss_cnt + 4'd1 == LOSS_N) begin
                miss_cnt <= 4'd0;
                state    <= HUNT;
                locked   <= 1'b0;
              end else begin
                miss_cnt <= miss_cnt + 4'd1;
              end
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: default instance (a) plus a narrow-counter,
// high-loss-threshold instance (b) for saturation and async reset.
module tb_lfsr_checker;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [7:0]  din_a = 8'h00, din_b = 8'h00;
  logic        valid_a = 1'b0, valid_b = 1'b0;
  logic        clr_a = 1'b0, clr_b = 1'b0;
  logic        locked_a, pulse_a, locked_b, pulse_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          sel;
    logic        l;
    logic        p;
    logic [15:0] c;
    string       tag;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  lfsr_checker u_a (
    .clk(clk), .resetn(resetn), .din(din_a), .din_valid(valid_a), .clr_cnt(clr_a),
    .locked(locked_a), .err_pulse(pulse_a), .err_cnt(cnt_a)
  );

  lfsr_checker #(.TAP_MASK(8'h0E), .LOCK_CNT(4), .LOSS_CNT(15), .CNT_W(4)) u_b (
    .clk(clk), .resetn(resetn), .din(din_b), .din_valid(valid_b), .clr_cnt(clr_b),
    .locked(locked_b), .err_pulse(pulse_b), .err_cnt(cnt_b)
  );

  function automatic logic [7:0] nxt(input logic [7:0] s);
    return {s[6:0], s[3] ^ s[2] ^ s[1]};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic compare_head();
    exp_t e;
    e = sb.pop_front();
    if (e.sel) begin
      chk({e.tag, ".locked"}, {15'd0, locked_b}, {15'd0, e.l});
      chk({e.tag, ".pulse"},  {15'd0, pulse_b},  {15'd0, e.p});
      chk({e.tag, ".cnt"},    {12'd0, cnt_b},    e.c);
    end else begin
      chk({e.tag, ".locked"}, {15'd0, locked_a}, {15'd0, e.l});
      chk({e.tag, ".pulse"},  {15'd0, pulse_a},  {15'd0, e.p});
      chk({e.tag, ".cnt"},    cnt_a,             e.c);
    end
  endtask

  task automatic push(input bit sel, input logic l, input logic p,
                      input logic [15:0] c, input string tag);
    exp_t e;
    e.sel = sel; e.l = l; e.p = p; e.c = c; e.tag = tag;
    sb.push_back(e);
  endtask

  // one clock of stimulus on the selected instance; the other sees idle inputs
  task automatic step(input bit sel, input logic [7:0] d, input logic v, input logic c,
                      input logic el, input logic ep, input logic [15:0] ec, input string tag);
    @(negedge clk);
    din_a = sel ? 8'h00 : d;  valid_a = sel ? 1'b0 : v;  clr_a = sel ? 1'b0 : c;
    din_b = sel ? d : 8'h00;  valid_b = sel ? v : 1'b0;  clr_b = sel ? c : 1'b0;
    push(sel, el, ep, ec, tag);
    @(posedge clk);
    #1;
    compare_head();
  endtask

  initial begin
    logic [7:0]  s;
    logic [15:0] n;

    #12;
    push(0, 0, 0, 16'd0, "reset_a"); compare_head();
    push(1, 0, 0, 16'd0, "reset_b"); compare_head();
    @(negedge clk) resetn = 1'b1;

    // lock acquisition: 01,02,05,0B stay unlocked, 16 locks
    s = 8'h01;
    for (int i = 0; i < 5; i++) begin
      step(0, s, 1, 0, (i == 4), 0, 16'd0, "acquire");
      s = nxt(s);
    end

    // single error 2D vs 2C; flywheel keeps 58, B1 aligned
    step(0, 8'h2D, 1, 0, 1, 1, 16'd1, "single_err"); s = nxt(s);
    step(0, s,     1, 0, 1, 0, 16'd1, "after_err1"); s = nxt(s);
    step(0, s,     1, 0, 1, 0, 16'd1, "after_err2"); s = nxt(s);

    // gap of invalid cycles, then resume with the correct word
    for (int i = 0; i < 5; i++) step(0, 8'hFF, 0, 0, 1, 0, 16'd1, "gap");
    step(0, s, 1, 0, 1, 0, 16'd1, "resume"); s = nxt(s);

    step(0, 8'h00, 0, 1, 1, 0, 16'd0, "clr_idle");

    // loss of lock on three consecutive zero words
    step(0, 8'h00, 1, 0, 1, 1, 16'd1, "loss1");
    step(0, 8'h00, 1, 0, 1, 1, 16'd2, "loss2");
    step(0, 8'h00, 1, 0, 0, 1, 16'd3, "loss3");
    step(0, 8'h00, 1, 0, 0, 0, 16'd3, "hunt_zero");

    // re-seed in VERIFY: AA and 55 both re-seed, lock after 4 matches past 55
    step(0, 8'h01, 1, 0, 0, 0, 16'd3, "seed01");
    step(0, 8'h02, 1, 0, 0, 0, 16'd3, "match02");
    step(0, 8'hAA, 1, 0, 0, 0, 16'd3, "reseedAA");
    step(0, 8'h55, 1, 0, 0, 0, 16'd3, "reseed55");
    s = nxt(8'h55);
    for (int i = 0; i < 4; i++) begin
      step(0, s, 1, 0, (i == 3), 0, 16'd3, "relock");
      s = nxt(s);
    end

    // bring err_cnt to 7 with alternating bad/good words, then clear on a mismatch
    n = 16'd3;
    for (int i = 0; i < 4; i++) begin
      n++;
      step(0, s ^ 8'h80, 1, 0, 1, 1, n, "count_bad"); s = nxt(s);
      step(0, s,         1, 0, 1, 0, n, "count_good"); s = nxt(s);
    end
    step(0, s ^ 8'h80, 1, 1, 1, 1, 16'd1, "clr_with_err"); s = nxt(s);
    step(0, s,         0, 1, 1, 0, 16'd0, "clr_only");

    // instance b: lock, then 20 mismatches with a good word every fifth
    s = 8'h01;
    for (int i = 0; i < 5; i++) begin
      step(1, s, 1, 0, (i == 4), 0, 16'd0, "b_acquire");
      s = nxt(s);
    end
    n = 16'd0;
    for (int i = 0; i < 25; i++) begin
      if (i % 5 == 4) begin
        step(1, s, 1, 0, 1, 0, n, "b_good");
      end else begin
        if (n < 16'd15) n++;
        step(1, s ^ 8'h01, 1, 0, 1, 1, n, "b_sat");
      end
      s = nxt(s);
    end
    step(1, s ^ 8'h01, 1, 0, 1, 1, 16'd15, "b_sat_hold");

    // async reset between clock edges clears everything at once
    #2 resetn = 1'b0;
    #1;
    push(1, 0, 0, 16'd0, "async_rst_b"); compare_head();
    push(0, 0, 0, 16'd0, "async_rst_a"); compare_head();

    @(negedge clk) resetn = 1'b1;
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    errors++;
    $display("FAIL timeout: simulation did not finish within bound");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
